// File: rtl/matrix_accel_sequencer_pkg.sv
// Shared definitions for the matrix accelerator sequencer: state encoding,
// default geometry/latency constants and derived lane-packing widths.
package matrix_accel_sequencer_pkg;

  localparam int DEF_IN_PORTS  = 4;
  localparam int DEF_OUT_PORTS = 4;
  localparam int DEF_BIT_LEN   = 16;
  localparam int DEF_ADDR_LEN  = 8;
  localparam int DEF_K_W       = 5;
  localparam int DEF_MULT_LAT  = 3;
  localparam int DEF_XBAR_LAT  = 1;
  localparam int DEF_ADD_LAT   = 1;
  localparam int DEF_TIMER_W   = 8;

  localparam int DEF_OP_W  = DEF_IN_PORTS * DEF_BIT_LEN;
  localparam int DEF_ACC_W = DEF_IN_PORTS * DEF_BIT_LEN * 2;
  localparam int DEF_SUM_W = DEF_OUT_PORTS * DEF_BIT_LEN * 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_DRAIN,
    S_OUT
  } state_t;

endpackage

// File: rtl/matrix_accel_sequencer_if.sv
// Host-side command/operand/result handshakes plus the accelerator control
// bus; master is the sequencer, slave is the host and accelerator together.
interface matrix_accel_sequencer_if #(
  parameter int IN_PORTS  = matrix_accel_sequencer_pkg::DEF_IN_PORTS,
  parameter int OUT_PORTS = matrix_accel_sequencer_pkg::DEF_OUT_PORTS,
  parameter int BIT_LEN   = matrix_accel_sequencer_pkg::DEF_BIT_LEN,
  parameter int ADDR_LEN  = matrix_accel_sequencer_pkg::DEF_ADDR_LEN,
  parameter int K_W       = matrix_accel_sequencer_pkg::DEF_K_W
);
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [K_W-1:0]                   cmd_k;
  logic [ADDR_LEN-1:0]              cmd_addr;
  logic                             cmd_direct;
  logic                             op_valid;
  logic                             op_ready;
  logic [IN_PORTS*BIT_LEN-1:0]      op_a;
  logic [IN_PORTS*BIT_LEN-1:0]      op_b;
  logic [IN_PORTS*BIT_LEN*2-1:0]    acc_multiplier;
  logic [IN_PORTS*BIT_LEN*2-1:0]    acc_multiplicand;
  logic [ADDR_LEN-1:0]              acc_addr;
  logic                             acc_direct;
  logic                             acc_mstart;
  logic                             acc_bufferrd;
  logic [OUT_PORTS-1:0]             acc_add;
  logic                             acc_clr;
  logic [OUT_PORTS*BIT_LEN*2-1:0]   acc_sum;
  logic                             res_valid;
  logic                             res_ready;
  logic [OUT_PORTS*BIT_LEN*2-1:0]   res_data;
  logic                             busy;

  modport master (
    input  cmd_valid, cmd_k, cmd_addr, cmd_direct, op_valid, op_a, op_b,
           acc_sum, res_ready,
    output cmd_ready, op_ready, acc_multiplier, acc_multiplicand, acc_addr,
           acc_direct, acc_mstart, acc_bufferrd, acc_add, acc_clr,
           res_valid, res_data, busy
  );

  modport slave (
    output cmd_valid, cmd_k, cmd_addr, cmd_direct, op_valid, op_a, op_b,
           acc_sum, res_ready,
    input  cmd_ready, op_ready, acc_multiplier, acc_multiplicand, acc_addr,
           acc_direct, acc_mstart, acc_bufferrd, acc_add, acc_clr,
           res_valid, res_data, busy
  );
endinterface

// File: rtl/matrix_step_timer.sv
// Loadable down-counter; done is high on the last cycle of a loaded count
// (a count of N keeps a waiting state for exactly N cycles).
module matrix_step_timer #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         run,
  output logic         done
);
  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load)
      count_next = load_value;
    else if (run && count_reg != '0)
      count_next = count_reg - W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign done = (count_reg <= W'(1));
endmodule

// File: rtl/matrix_accel_sequencer.sv
// Dot-product command sequencer: streams K operand vectors through the
// accelerator multipliers, pulses Add per step and returns the summed lanes.
module matrix_accel_sequencer
  import matrix_accel_sequencer_pkg::*;
#(
  parameter int IN_PORTS  = DEF_IN_PORTS,
  parameter int OUT_PORTS = DEF_OUT_PORTS,
  parameter int BIT_LEN   = DEF_BIT_LEN,
  parameter int ADDR_LEN  = DEF_ADDR_LEN,
  parameter int K_W       = DEF_K_W,
  parameter int MULT_LAT  = DEF_MULT_LAT,
  parameter int XBAR_LAT  = DEF_XBAR_LAT,
  parameter int ADD_LAT   = DEF_ADD_LAT
) (
  input logic                      Clk,
  input logic                      Rst,
  matrix_accel_sequencer_if.master bus
);
  localparam int OP_W    = IN_PORTS * BIT_LEN;
  localparam int SUM_W   = OUT_PORTS * BIT_LEN * 2;
  localparam int TIMER_W = DEF_TIMER_W;

  state_t state_reg, state_next;

  logic [K_W-1:0]      k_reg;
  logic [ADDR_LEN-1:0] addr_reg;
  logic                direct_reg;
  logic [OP_W-1:0]     op_a_reg;
  logic [OP_W-1:0]     op_b_reg;
  logic [SUM_W-1:0]    res_reg;

  logic               cmd_take, op_take, step_dec, capture;
  logic               timer_load, timer_run, timer_done;
  logic [TIMER_W-1:0] timer_value;

  matrix_step_timer #(.W(TIMER_W)) u_timer (
    .Clk        (Clk),
    .Rst        (Rst),
    .load       (timer_load),
    .load_value (timer_value),
    .run        (timer_run),
    .done       (timer_done)
  );

  always_ff @(posedge Clk) begin
    if (Rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    bus.cmd_ready    = 1'b0;
    bus.op_ready     = 1'b0;
    bus.acc_mstart   = 1'b0;
    bus.acc_bufferrd = 1'b0;
    bus.acc_add      = '0;
    bus.acc_clr      = 1'b0;
    bus.res_valid    = 1'b0;
    cmd_take         = 1'b0;
    op_take          = 1'b0;
    step_dec         = 1'b0;
    capture          = 1'b0;
    timer_load       = 1'b0;
    timer_run        = 1'b0;
    timer_value      = '0;
    case (state_reg)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          cmd_take   = 1'b1;
          state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        bus.acc_clr = 1'b1;
        if (k_reg != '0) begin
          state_next = S_LOAD;
        end else begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(ADD_LAT);
          state_next  = S_DRAIN;
        end
      end
      S_LOAD: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) begin
          op_take    = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.acc_mstart   = 1'b1;
        bus.acc_bufferrd = 1'b1;
        timer_load       = 1'b1;
        timer_value      = TIMER_W'(MULT_LAT + XBAR_LAT);
        state_next       = S_WAIT;
      end
      S_WAIT: begin
        timer_run = 1'b1;
        if (timer_done)
          state_next = S_ACCUM;
      end
      S_ACCUM: begin
        bus.acc_add = '1;
        step_dec    = 1'b1;
        // k_reg still holds the pre-decrement count here
        if (k_reg == K_W'(1)) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(ADD_LAT);
          state_next  = S_DRAIN;
        end else begin
          state_next = S_LOAD;
        end
      end
      S_DRAIN: begin
        timer_run = 1'b1;
        if (timer_done) begin
          capture    = 1'b1;
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      k_reg      <= '0;
      addr_reg   <= '0;
      direct_reg <= 1'b0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      res_reg    <= '0;
    end else begin
      if (cmd_take) begin
        k_reg      <= bus.cmd_k;
        addr_reg   <= bus.cmd_addr;
        direct_reg <= bus.cmd_direct;
      end else if (step_dec) begin
        k_reg <= k_reg - K_W'(1);
      end
      if (op_take) begin
        op_a_reg <= bus.op_a;
        op_b_reg <= bus.op_b;
      end
      if (capture)
        res_reg <= bus.acc_sum;
    end
  end

  // Multiplier ports are twice the operand width; lanes sit in the low half.
  assign bus.acc_multiplier   = {{OP_W{1'b0}}, op_a_reg};
  assign bus.acc_multiplicand = {{OP_W{1'b0}}, op_b_reg};
  assign bus.acc_addr         = addr_reg;
  assign bus.acc_direct       = direct_reg;
  assign bus.res_data         = res_reg;
  assign bus.busy             = (state_reg != S_IDLE);
endmodule
